// File: rtl/pc_pkg.sv
// Shared constants and next-PC source encoding for the fetch program-counter unit.
package pc_pkg;

  localparam int unsigned PC_AW        = 27;
  localparam int unsigned PC_RESET     = 16268;
  localparam int unsigned PC_STEP      = 4;
  localparam int unsigned PC_RAS_DEPTH = 4;

  typedef enum logic [1:0] {
    SRC_FLUSH = 2'd0,
    SRC_RAS   = 2'd1,
    SRC_NPC   = 2'd2,
    SRC_SEQ   = 2'd3
  } pc_src_e;

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack: push, pop and in-place replace, with a sticky
// flag raised when a push overwrites the oldest live entry.
module ras_stack import pc_pkg::*; #(
  parameter int unsigned AW    = PC_AW,
  parameter int unsigned DEPTH = PC_RAS_DEPTH
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [AW-1:0] wdata,
  output logic [AW-1:0] top,
  output logic          empty,
  output logic          full,
  output logic          ovf
);

  localparam int unsigned TPW = $clog2(DEPTH);
  localparam int unsigned CW  = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

  logic [AW-1:0]  mem_r [DEPTH];
  logic [TPW-1:0] tp_r;
  logic [CW-1:0]  cnt_r;
  logic           ovf_r;
  logic           do_push_s;
  logic           do_pop_s;
  logic           do_repl_s;
  logic           empty_s;
  logic           full_s;

  assign empty_s = (cnt_r == CW'(0));
  assign full_s  = (cnt_r == CNT_MAX);
  assign top     = mem_r[tp_r];
  assign empty   = empty_s;
  assign full    = full_s;
  assign ovf     = ovf_r;

  // Resolve push/pop into push, pop or replace; call+ret on an empty stack is a plain push.
  always_comb begin
    do_repl_s = 1'b0;
    do_push_s = 1'b0;
    do_pop_s  = 1'b0;
    if (push && pop && !empty_s) begin
      do_repl_s = 1'b1;
    end else if (push) begin
      do_push_s = 1'b1;
    end else if (pop && !empty_s) begin
      do_pop_s = 1'b1;
    end else begin
      do_pop_s = 1'b0;
    end
  end

  // Pointer, occupancy and sticky overflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tp_r  <= TPW'(0);
      cnt_r <= CW'(0);
      ovf_r <= 1'b0;
    end else if (do_push_s) begin
      tp_r  <= tp_r + TPW'(1);
      cnt_r <= full_s ? cnt_r : cnt_r + CW'(1);
      ovf_r <= ovf_r | full_s;
    end else if (do_pop_s) begin
      tp_r  <= tp_r - TPW'(1);
      cnt_r <= cnt_r - CW'(1);
    end else begin
      tp_r  <= tp_r;
      cnt_r <= cnt_r;
    end
  end

  // Entry storage; cleared on reset so the stack never presents X as a target.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_r[i] <= AW'(0);
    end else if (do_push_s) begin
      mem_r[tp_r + TPW'(1)] <= wdata;
    end else if (do_repl_s) begin
      mem_r[tp_r] <= wdata;
    end else begin
      mem_r[tp_r] <= mem_r[tp_r];
    end
  end

endmodule

// File: rtl/pc_unit.sv
// Fetch program counter: flush > (stall hold) > RAS return > decode redirect > sequential.
module pc_unit import pc_pkg::*; #(
  parameter int unsigned    AW        = PC_AW,
  parameter logic [AW-1:0]  RESET_PC  = AW'(PC_RESET),
  parameter int unsigned    STEP      = PC_STEP,
  parameter int unsigned    RAS_DEPTH = PC_RAS_DEPTH
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          n_stall,
  input  logic          flush_en,
  input  logic [AW-1:0] flush_pc,
  input  logic          npc_en,
  input  logic [AW-1:0] npc,
  input  logic          call_en,
  input  logic          ret_en,
  output logic [AW-1:0] pc,
  output logic [AW-1:0] pc_seq,
  output logic          ras_empty,
  output logic          ras_full,
  output logic          ras_ovf,
  output logic          pc_misalign
);

  localparam int unsigned SW = (STEP > 1) ? $clog2(STEP) : 1;

  logic [AW-1:0] pc_r;
  logic [AW-1:0] pc_seq_s;
  logic [AW-1:0] next_pc_s;
  logic [AW-1:0] ras_top_s;
  logic          ras_empty_s;
  logic          adv_s;
  pc_src_e       src_s;

  assign pc_seq_s = pc_r + AW'(STEP);
  assign adv_s    = !flush_en && n_stall;
  assign pc       = pc_r;
  assign pc_seq   = pc_seq_s;
  assign ras_empty = ras_empty_s;

  ras_stack #(
    .AW    (AW),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk   (clk),
    .rst   (rst),
    .push  (call_en && adv_s),
    .pop   (ret_en && adv_s),
    .wdata (pc_seq_s),
    .top   (ras_top_s),
    .empty (ras_empty_s),
    .full  (ras_full),
    .ovf   (ras_ovf)
  );

  // Next-PC source priority; a return on an empty stack falls through.
  always_comb begin
    src_s = SRC_SEQ;
    if (flush_en) begin
      src_s = SRC_FLUSH;
    end else if (ret_en && !ras_empty_s) begin
      src_s = SRC_RAS;
    end else if (npc_en) begin
      src_s = SRC_NPC;
    end else begin
      src_s = SRC_SEQ;
    end
  end

  // Source select mux.
  always_comb begin
    next_pc_s = pc_seq_s;
    case (src_s)
      SRC_FLUSH: next_pc_s = flush_pc;
      SRC_RAS:   next_pc_s = ras_top_s;
      SRC_NPC:   next_pc_s = npc;
      SRC_SEQ:   next_pc_s = pc_seq_s;
      default:   next_pc_s = pc_seq_s;
    endcase
  end

  // PC register; flush overrides stall.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_r <= RESET_PC;
    end else if (flush_en || n_stall) begin
      pc_r <= next_pc_s;
    end else begin
      pc_r <= pc_r;
    end
  end

  if (STEP > 1) begin : g_misalign
    assign pc_misalign = (pc_r[SW-1:0] != SW'(0));
  end else begin : g_aligned
    assign pc_misalign = 1'b0;
  end

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: expected PCs queued at drive time, popped after each edge.
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        n_stall, flush_en, npc_en, call_en, ret_en;
  logic [26:0] flush_pc, npc, pc, pc_seq;
  logic        ras_empty, ras_full, ras_ovf, pc_misalign;

  logic        w_n_stall, w_npc_en;
  logic [7:0]  w_npc, w_pc, w_pc_seq;
  logic        w_empty, w_full, w_ovf, w_misalign;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  logic [26:0] exp_q [$];

  always #5 clk = ~clk;

  pc_unit dut (
    .clk(clk), .rst(rst), .n_stall(n_stall), .flush_en(flush_en), .flush_pc(flush_pc),
    .npc_en(npc_en), .npc(npc), .call_en(call_en), .ret_en(ret_en), .pc(pc), .pc_seq(pc_seq),
    .ras_empty(ras_empty), .ras_full(ras_full), .ras_ovf(ras_ovf), .pc_misalign(pc_misalign)
  );

  pc_unit #(.AW(8), .RESET_PC(8'd252), .STEP(4), .RAS_DEPTH(4)) dut_w (
    .clk(clk), .rst(rst), .n_stall(w_n_stall), .flush_en(1'b0), .flush_pc(8'd0),
    .npc_en(w_npc_en), .npc(w_npc), .call_en(1'b0), .ret_en(1'b0), .pc(w_pc), .pc_seq(w_pc_seq),
    .ras_empty(w_empty), .ras_full(w_full), .ras_ovf(w_ovf), .pc_misalign(w_misalign)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock with current inputs; the PC expected after the edge goes through the queue.
  task automatic cyc(input string tag, input logic [26:0] exp_pc);
    logic [26:0] e;
    exp_q.push_back(exp_pc);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk(tag, 32'(pc), 32'(e));
    chk({tag, "_seq"}, 32'(pc_seq), 32'(e + 27'd4));
  endtask

  task automatic idle();
    n_stall = 1'b1; flush_en = 1'b0; npc_en = 1'b0; call_en = 1'b0; ret_en = 1'b0;
  endtask

  initial begin
    rst = 1'b0; idle(); n_stall = 1'b0; flush_pc = 27'd0; npc = 27'd0;
    w_n_stall = 1'b0; w_npc_en = 1'b0; w_npc = 8'd0;
    #12;
    chk("rst_pc", 32'(pc), 32'd16268);
    chk("rst_seq", 32'(pc_seq), 32'd16272);
    chk("rst_empty", 32'(ras_empty), 32'd1);
    chk("rst_full", 32'(ras_full), 32'd0);
    chk("rst_ovf", 32'(ras_ovf), 32'd0);
    chk("rst_mis", 32'(pc_misalign), 32'd0);
    chk("w_rst_pc", 32'(w_pc), 32'd252);
    chk("w_rst_seq", 32'(w_pc_seq), 32'd0);
    @(posedge clk); #1; rst = 1'b1;

    // Sequential fetch
    idle();
    cyc("seq1", 27'd16272);
    cyc("seq2", 27'd16276);
    cyc("seq3", 27'd16280);

    // Stall holds even with decode redirect; flush overrides stall
    n_stall = 1'b0; npc_en = 1'b1; npc = 27'd100;
    cyc("stall_hold", 27'd16280);
    flush_en = 1'b1; flush_pc = 27'd200;
    cyc("stall_flush", 27'd200);
    chk("stall_empty", 32'(ras_empty), 32'd1);

    // Call with decode redirect, then return
    idle(); flush_en = 1'b1; flush_pc = 27'd1000;
    cyc("to_1000", 27'd1000);
    idle(); call_en = 1'b1; npc_en = 1'b1; npc = 27'd5000;
    cyc("call_npc", 27'd5000);
    chk("call_nonempty", 32'(ras_empty), 32'd0);
    idle();
    cyc("after_call", 27'd5004);
    ret_en = 1'b1;
    cyc("ret", 27'd1004);
    chk("ret_empty", 32'(ras_empty), 32'd1);

    // Overflow: calls from 10..50 push 14..54, 14 is lost
    idle(); flush_en = 1'b1; flush_pc = 27'd10;
    cyc("to_10", 27'd10);
    for (int i = 1; i <= 5; i++) begin
      idle(); call_en = 1'b1; npc_en = 1'b1; npc = 27'(10 * (i + 1));
      cyc("ovf_call", 27'(10 * (i + 1)));
      if (i == 4) begin
        chk("full4", 32'(ras_full), 32'd1);
        chk("noovf4", 32'(ras_ovf), 32'd0);
      end
    end
    chk("full5", 32'(ras_full), 32'd1);
    chk("ovf5", 32'(ras_ovf), 32'd1);
    for (int i = 0; i < 4; i++) begin
      idle(); ret_en = 1'b1;
      cyc("ovf_ret", 27'(54 - 10 * i));
    end
    chk("ovf_empty", 32'(ras_empty), 32'd1);
    idle(); ret_en = 1'b1;
    cyc("ret_underflow_seq", 27'd28);
    chk("ovf_sticky", 32'(ras_ovf), 32'd1);
    npc_en = 1'b1; npc = 27'd700;
    cyc("ret_underflow_npc", 27'd700);

    // Call+ret replaces top in place; flush blocks RAS changes
    idle(); flush_en = 1'b1; flush_pc = 27'd1000;
    cyc("to_1000b", 27'd1000);
    idle(); call_en = 1'b1; npc_en = 1'b1; npc = 27'd300;
    cyc("to_300", 27'd300);
    idle(); call_en = 1'b1; ret_en = 1'b1;
    cyc("callret", 27'd1004);
    chk("callret_empty", 32'(ras_empty), 32'd0);
    chk("callret_full", 32'(ras_full), 32'd0);
    flush_en = 1'b1; flush_pc = 27'd2000;
    cyc("callret_flush", 27'd2000);
    idle(); n_stall = 1'b0; call_en = 1'b1;
    cyc("stall_call", 27'd2000);
    idle(); ret_en = 1'b1;
    cyc("ret_replaced", 27'd304);
    chk("replaced_empty", 32'(ras_empty), 32'd1);

    // Misalignment on the main unit
    idle(); npc_en = 1'b1; npc = 27'd1002;
    cyc("mis_npc", 27'd1002);
    chk("mis_main", 32'(pc_misalign), 32'd1);

    // 8-bit wrap
    idle(); n_stall = 1'b0;
    w_n_stall = 1'b1;
    @(posedge clk); #1;
    chk("w_wrap", 32'(w_pc), 32'd0);
    chk("w_mis0", 32'(w_misalign), 32'd0);
    w_npc_en = 1'b1; w_npc = 8'h02;
    @(posedge clk); #1;
    chk("w_npc", 32'(w_pc), 32'd2);
    chk("w_mis1", 32'(w_misalign), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
